// File: rtl/sdram_port_arbiter_if.sv
// Upstream request/response ports and the single controller-facing port of the SDRAM arbiter.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BYTE      = 2
);
    logic [NUM_PORTS-1:0]      up_req_valid;
    logic [NUM_PORTS-1:0]      up_req_write;
    logic [NUM_PORTS*AW-1:0]   up_req_address;
    logic [NUM_PORTS*DW-1:0]   up_req_writedata;
    logic [NUM_PORTS*BYTE-1:0] up_req_byteenable;
    logic [NUM_PORTS-1:0]      up_req_ready;
    logic [NUM_PORTS-1:0]      up_resp_valid;
    logic [DW-1:0]             up_resp_readdata;

    logic                      bus_req_valid;
    logic                      bus_req_write;
    logic [AW-1:0]             bus_req_address;
    logic [DW-1:0]             bus_req_writedata;
    logic [BYTE-1:0]           bus_req_byteenable;
    logic                      bus_req_ready;
    logic                      bus_resp_valid;
    logic [DW-1:0]             bus_resp_readdata;

    // Arbiter side
    modport slave (
        input  up_req_valid, up_req_write, up_req_address, up_req_writedata, up_req_byteenable,
        output up_req_ready, up_resp_valid, up_resp_readdata,
        output bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        input  bus_req_ready, bus_resp_valid, bus_resp_readdata
    );

    // Environment side (masters plus controller)
    modport master (
        output up_req_valid, up_req_write, up_req_address, up_req_writedata, up_req_byteenable,
        input  up_req_ready, up_resp_valid, up_resp_readdata,
        input  bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        output bus_req_ready, bus_resp_valid, bus_resp_readdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_PORTS masters,
// with an in-order tag FIFO steering read responses back to their issuing port.
//
// state   | meaning
// S_EMPTY | slot free, arbitrate and accept one upstream request
// S_FULL  | slot holds a request, presented to controller until accepted
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BYTE      = 2,
    parameter int MAX_RD    = 4,
    parameter int PW        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_port_arbiter_if.slave  arb,
    output logic                 resp_orphan
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;
    localparam int FAW = $clog2(MAX_RD);
    localparam int CW  = FAW + 1;

    logic [0:0]     state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  winner;
    logic           found;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic [NUM_PORTS-1:0] eligible;

    logic [PW-1:0]  tag_mem [MAX_RD];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic [CW-1:0]  count;
    logic [PW-1:0]  head;

    logic            slot_write;
    logic [AW-1:0]   slot_address;
    logic [DW-1:0]   slot_writedata;
    logic [BYTE-1:0] slot_byteenable;

    assign fifo_full = (count == CW'(MAX_RD));
    assign eligible  = arb.up_req_valid & (arb.up_req_write | {NUM_PORTS{~fifo_full}});

    // First eligible port at or after rr_ptr, wrapping around
    always_comb begin
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && eligible[j]) begin
                found  = 1'b1;
                winner = PW'(j);
            end
        end
    end

    assign accept = !reset && (state == S_EMPTY) && found;
    assign push   = accept && !arb.up_req_write[winner];
    assign pop    = arb.bus_resp_valid && (count != '0);
    assign head   = tag_mem[rd_ptr];

    always_comb begin
        arb.up_req_ready  = '0;
        arb.up_resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            arb.up_req_ready[i]  = accept && (winner == PW'(i));
            arb.up_resp_valid[i] = !reset && pop && (head == PW'(i));
        end
    end

    assign arb.up_resp_readdata   = arb.bus_resp_readdata;
    assign arb.bus_req_valid      = (state == S_FULL);
    assign arb.bus_req_write      = slot_write;
    assign arb.bus_req_address    = slot_address;
    assign arb.bus_req_writedata  = slot_writedata;
    assign arb.bus_req_byteenable = slot_byteenable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_EMPTY;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_EMPTY: if (accept) begin
                    state  <= S_FULL;
                    rr_ptr <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + PW'(1);
                end
                S_FULL: if (arb.bus_req_ready) state <= S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Slot fields only load on accept, so they stay stable while S_FULL
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_write      <= 1'b0;
            slot_address    <= '0;
            slot_writedata  <= '0;
            slot_byteenable <= '0;
        end else if (accept) begin
            slot_write      <= arb.up_req_write[winner];
            slot_address    <= arb.up_req_address[int'(winner)*AW +: AW];
            slot_writedata  <= arb.up_req_writedata[int'(winner)*DW +: DW];
            slot_byteenable <= arb.up_req_byteenable[int'(winner)*BYTE +: BYTE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + FAW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + FAW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                        resp_orphan <= 1'b0;
        else if (arb.bus_resp_valid && (count == '0))     resp_orphan <= 1'b1;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table plus hand-written corner sequences.
module tb_sdram_port_arbiter;
    localparam int NP = 2, AW = 24, DW = 16, BY = 2;

    logic clk = 1'b0;
    logic reset;
    logic resp_orphan;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .BYTE(BY)) bif ();

    sdram_port_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .BYTE(BY), .MAX_RD(4), .PW(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .arb         (bif.slave),
        .resp_orphan (resp_orphan)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  w;
        logic        br;
        logic        rsv;
        logic [15:0] rdat;
        logic [1:0]  e_rdy;
        logic        e_bv;
        logic [23:0] e_addr;
        logic [15:0] e_wd;
        logic [1:0]  e_rv;
        logic        e_orph;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic br,
                         input logic rsv, input logic [15:0] rdat);
        bif.up_req_valid      = v;
        bif.up_req_write      = w;
        bif.bus_req_ready     = br;
        bif.bus_resp_valid    = rsv;
        bif.bus_resp_readdata = rdat;
    endtask

    initial begin
        int accepts;
        bif.up_req_address    = {24'h000200, 24'h000100};
        bif.up_req_writedata  = {16'h1234, 16'hBEEF};
        bif.up_req_byteenable = {2'b01, 2'b11};
        drive(2'b11, 2'b11, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;

        //          v      w     br    rsv   rdat     e_rdy  e_bv  e_addr      e_wd      e_rv   e_orph
        vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 16'h0,    2'b01, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000100, 16'hBEEF, 2'b00, 1'b0};
        vecs[3]  = '{2'b00, 2'b00, 1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000100, 16'hBEEF, 2'b00, 1'b0};
        vecs[4]  = '{2'b11, 2'b11, 1'b1, 1'b0, 16'h0,    2'b10, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000200, 16'h1234, 2'b00, 1'b0};
        vecs[6]  = '{2'b11, 2'b11, 1'b1, 1'b0, 16'h0,    2'b01, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[7]  = '{2'b11, 2'b11, 1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000100, 16'hBEEF, 2'b00, 1'b0};
        vecs[8]  = '{2'b11, 2'b11, 1'b1, 1'b0, 16'h0,    2'b10, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000200, 16'h1234, 2'b00, 1'b0};
        vecs[10] = '{2'b10, 2'b00, 1'b0, 1'b0, 16'h0,    2'b10, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[11] = '{2'b01, 2'b00, 1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 24'h000200, 16'h1234, 2'b00, 1'b0};
        vecs[12] = '{2'b01, 2'b00, 1'b0, 1'b0, 16'h0,    2'b01, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[13] = '{2'b00, 2'b00, 1'b1, 1'b1, 16'h1111, 2'b00, 1'b1, 24'h000100, 16'hBEEF, 2'b10, 1'b0};
        vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b1, 16'h2222, 2'b00, 1'b0, 24'h0,      16'h0,    2'b01, 1'b0};
        vecs[15] = '{2'b00, 2'b00, 1'b0, 1'b1, 16'h3333, 2'b00, 1'b0, 24'h0,      16'h0,    2'b00, 1'b0};
        vecs[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 24'h0,      16'h0,    2'b00, 1'b1};

        tick;
        tick;
        check("rst_req_ready", 32'(bif.up_req_ready), 32'h0);
        check("rst_bus_valid", 32'(bif.bus_req_valid), 32'h0);
        check("rst_orphan", 32'(resp_orphan), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].br, vecs[i].rsv, vecs[i].rdat);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bif.up_req_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_bus_valid", i), 32'(bif.bus_req_valid), 32'(vecs[i].e_bv));
            if (vecs[i].e_bv) begin
                check($sformatf("v%0d_addr", i), 32'(bif.bus_req_address), 32'(vecs[i].e_addr));
                check($sformatf("v%0d_wdata", i), 32'(bif.bus_req_writedata), 32'(vecs[i].e_wd));
            end
            check($sformatf("v%0d_resp_valid", i), 32'(bif.up_resp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].rsv)
                check($sformatf("v%0d_rdata", i), 32'(bif.up_resp_readdata), 32'(vecs[i].rdat));
            check($sformatf("v%0d_orphan", i), 32'(resp_orphan), 32'(vecs[i].e_orph));
            tick;
        end

        // Fill the tag FIFO with four port-0 reads
        drive(2'b01, 2'b00, 1'b1, 1'b0, 16'h0);
        accepts = 0;
        for (int c = 0; c < 20 && accepts < 4; c++) begin
            #1;
            if (bif.up_req_ready[0]) accepts++;
            tick;
        end
        check("fill_accepts", 32'(accepts), 32'd4);
        tick;
        #1;
        check("full_blocks_read", 32'(bif.up_req_ready), 32'h0);
        tick;
        drive(2'b11, 2'b10, 1'b1, 1'b0, 16'h0);
        #1;
        check("write_while_full", 32'(bif.up_req_ready), 32'b10);
        tick;
        drive(2'b00, 2'b00, 1'b1, 1'b0, 16'h0);
        #1;
        check("full_write_bus", 32'(bif.bus_req_write), 32'h1);
        check("full_write_be", 32'(bif.bus_req_byteenable), 32'b01);
        tick;
        drive(2'b01, 2'b00, 1'b1, 1'b1, 16'hAAAA);
        #1;
        check("pop_cycle_ready", 32'(bif.up_req_ready), 32'h0);
        check("pop_resp_valid", 32'(bif.up_resp_valid), 32'b01);
        check("pop_rdata", 32'(bif.up_resp_readdata), 32'hAAAA);
        tick;
        drive(2'b01, 2'b00, 1'b1, 1'b0, 16'h0);
        #1;
        check("read_after_pop", 32'(bif.up_req_ready), 32'b01);
        check("orphan_sticky", 32'(resp_orphan), 32'h1);
        tick;

        // Reset clears everything, including the sticky orphan flag
        drive(2'b00, 2'b00, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("reset_clears_orphan", 32'(resp_orphan), 32'h0);
        check("reset_clears_slot", 32'(bif.bus_req_valid), 32'h0);

        // Two reads pending with the slot full, then reset
        drive(2'b01, 2'b00, 1'b0, 1'b0, 16'h0);
        #1;
        check("pre_rst_read1", 32'(bif.up_req_ready), 32'b01);
        tick;
        drive(2'b00, 2'b00, 1'b1, 1'b0, 16'h0);
        tick;
        drive(2'b01, 2'b00, 1'b0, 1'b0, 16'h0);
        #1;
        check("pre_rst_read2", 32'(bif.up_req_ready), 32'b01);
        tick;
        drive(2'b00, 2'b00, 1'b0, 1'b0, 16'h0);
        #1;
        check("pre_rst_slot_full", 32'(bif.bus_req_valid), 32'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("mid_rst_slot", 32'(bif.bus_req_valid), 32'h0);
        drive(2'b11, 2'b11, 1'b0, 1'b1, 16'h5555);
        #1;
        check("mid_rst_rr_ptr", 32'(bif.up_req_ready), 32'b01);
        check("mid_rst_resp", 32'(bif.up_resp_valid), 32'h0);
        tick;
        drive(2'b00, 2'b00, 1'b0, 1'b0, 16'h0);
        #1;
        check("mid_rst_orphan", 32'(resp_orphan), 32'h1);
        check("mid_rst_grant_addr", 32'(bif.bus_req_address), 32'h000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
